// File: rtl/priority_encoder_seq.sv
// ============================================================================
// Module   : priority_encoder_seq
// Brief    : Serialises the set-bit indices of a captured request vector over
//            a valid/ready stream, with popcount and an explicit all-zero beat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module priority_encoder_seq #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic [IDX_W:0]   out_cnt,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W:0]   cnt_q,     cnt_d;

  logic [IDX_W-1:0] w_sel_idx;
  logic [WIDTH-1:0] w_sel_mask;
  logic             w_single;
  logic             w_in_fire;
  logic             w_out_fire;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + (IDX_W+1)'(v[i]);
    end
    return c;
  endfunction

  // Later loop iterations overwrite earlier ones, so scan order picks the winner.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (pending_q[i]) w_sel_idx = IDX_W'(i);
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        w_sel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (pending_q[i]) w_sel_idx = IDX_W'(i);
        end
      end
    end
  endgenerate

  assign w_sel_mask = {{(WIDTH-1){1'b0}}, 1'b1} << w_sel_idx;
  assign w_single   = (pending_q != '0) &&
                      ((pending_q & (pending_q - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

  // in_ready is gated by rst_n so it stays low for the whole reset assertion.
  assign in_ready   = rst_n & en & (state_q == S_IDLE);
  assign out_valid  = en & (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_in_fire) begin
          pending_d = in_data;
          cnt_d     = popcount(in_data);
          state_d   = (in_data == '0) ? S_ZERO : S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_out_fire) begin
          pending_d = pending_q & ~w_sel_mask;
          if (w_single) begin
            state_d   = S_IDLE;
            pending_d = '0;
          end
        end
      end
      S_ZERO: begin
        if (w_out_fire) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    out_idx  = '0;
    out_last = 1'b0;
    out_none = 1'b0;
    out_cnt  = cnt_q;
    case (state_q)
      S_SCAN: begin
        out_idx  = w_sel_idx;
        out_last = w_single;
      end
      S_ZERO: begin
        out_last = 1'b1;
        out_none = 1'b1;
        out_cnt  = '0;
      end
      default: begin
        out_idx  = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_seq.sv
// ============================================================================
// Module   : tb_priority_encoder_seq
// Brief    : Vector table, hand sequences and random vectors for both scan
//            orders, checked against a set-bit list model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_priority_encoder_seq;

  logic       clk = 1'b0;
  logic       rst_n, en, in_valid, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_none, a_busy;
  logic [2:0] a_out_idx;
  logic [3:0] a_out_cnt;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_none, b_busy;
  logic [2:0] b_out_idx;
  logic [3:0] b_out_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  priority_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idx(a_out_idx), .out_last(a_out_last), .out_none(a_out_none),
    .out_cnt(a_out_cnt), .busy(a_busy));

  priority_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_idx(b_out_idx), .out_last(b_out_last), .out_none(b_out_none),
    .out_cnt(b_out_cnt), .busy(b_busy));

  typedef struct {
    logic [7:0] data;
    int         cnt;
    int         first_lsb;
    int         first_msb;
    int         hold;
    int         pause;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_in_ready_a", a_in_ready, 1);
    chk("idle_in_ready_b", b_in_ready, 1);
    chk("idle_busy", a_busy | b_busy, 0);
    chk("idle_out_valid", a_out_valid | b_out_valid, 0);
    chk("idle_fields", {a_out_idx, a_out_last, a_out_none, b_out_idx, b_out_last, b_out_none}, 0);
  endtask

  // Captures one vector and drains it; the model is the ordered list of set bits.
  task automatic run_vector(input logic [7:0] data, input int exp_cnt, input int first_a,
                            input int first_b, input int stall_pct, input bit garbage,
                            input int hold_first, input int pause_after);
    int qa[$];
    int qb[$];
    int popped = 0;
    int held   = 0;
    int guard  = 0;
    bit paused = 0;
    bit first  = 1;
    int cnt;
    chk_idle();
    in_valid  = 1'b1;
    in_data   = data;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (data[b]) begin
        qa.push_back(b);
        qb.push_front(b);
      end
    end
    cnt = qa.size();
    if (data == 8'h00) begin
      qa.push_back(0);
      qb.push_back(0);
    end
    while (qa.size() > 0 && guard < 300) begin
      guard++;
      if (pause_after >= 0 && popped == pause_after && !paused) begin
        paused    = 1;
        en        = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
          #1;
          chk("pause_out_valid", a_out_valid | b_out_valid, 0);
          chk("pause_in_ready", a_in_ready | b_in_ready, 0);
          chk("pause_busy", a_busy & b_busy, 1);
          @(negedge clk);
        end
        en = 1'b1;
        #1;
      end
      if (first && exp_cnt >= 0) begin
        chk("tbl_cnt", a_out_cnt, exp_cnt);
        chk("tbl_first_lsb", a_out_idx, first_a);
        chk("tbl_first_msb", b_out_idx, first_b);
      end
      first = 0;
      chk("beat_valid", a_out_valid & b_out_valid, 1);
      chk("beat_busy", a_busy & b_busy, 1);
      chk("beat_in_ready", a_in_ready | b_in_ready, 0);
      chk("beat_idx_lsb", a_out_idx, qa[0]);
      chk("beat_idx_msb", b_out_idx, qb[0]);
      chk("beat_last_lsb", a_out_last, int'(qa.size() == 1));
      chk("beat_last_msb", b_out_last, int'(qb.size() == 1));
      chk("beat_none", a_out_none + 2 * b_out_none, (data == 8'h00) ? 3 : 0);
      chk("beat_cnt_lsb", a_out_cnt, cnt);
      chk("beat_cnt_msb", b_out_cnt, cnt);
      if (held < hold_first) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      if (garbage) begin
        in_valid = $urandom_range(1);
        in_data  = 8'hFF;
      end
      @(negedge clk);
      if (out_ready) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        popped++;
      end
    end
    if (qa.size() > 0) chk("drain_timeout", qa.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int         pa;
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", a_in_ready | b_in_ready, 0);
    chk("rst_out_valid", a_out_valid | b_out_valid, 0);
    chk("rst_busy_cnt", {a_busy, b_busy, a_out_cnt, b_out_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    tbl = '{
      '{8'h05, 2, 0, 2, 0, -1},
      '{8'hA0, 2, 5, 7, 0, -1},
      '{8'h00, 0, 0, 0, 0, -1},
      '{8'h0C, 2, 2, 3, 3, -1},
      '{8'hFF, 8, 0, 7, 0,  3},
      '{8'h80, 1, 7, 7, 2, -1},
      '{8'h01, 1, 0, 0, 0, -1}
    };
    for (int i = 0; i < 7; i++) begin
      run_vector(tbl[i].data, tbl[i].cnt, tbl[i].first_lsb, tbl[i].first_msb,
                 0, 1'b1, tbl[i].hold, tbl[i].pause);
    end

    // Reset in the middle of a scan drops the rest of the vector.
    chk_idle();
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_rst_first_lsb", a_out_idx, 4);
    chk("mid_rst_first_msb", b_out_idx, 7);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", a_busy & b_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_out_valid | b_out_valid, 0);
    chk("mid_rst_in_ready", a_in_ready | b_in_ready, 0);
    chk("mid_rst_busy0", a_busy | b_busy, 0);
    chk("mid_rst_fields", {a_out_idx, a_out_last, a_out_none, a_out_cnt, b_out_idx, b_out_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", a_in_ready & b_in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_beat", a_out_valid | b_out_valid | a_busy | b_busy, 0);
    end
    out_ready = 1'b0;

    // en low in IDLE blocks acceptance.
    en = 1'b0;
    #1;
    chk("en0_in_ready", a_in_ready | b_in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    chk("en0_no_capture", a_busy | b_busy, 0);
    in_valid = 1'b0;
    en       = 1'b1;
    #1;
    run_vector(8'h02, 1, 1, 1, 0, 1'b0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(7))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      pa = -1;
      if (d != 8'h00 && $urandom_range(3) == 0) pa = $urandom_range($countones(d) - 1);
      run_vector(d, -1, 0, 0, 30, 1'b1, 0, pa);
    end
    chk_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_encoder_seq.md
Name: priority_encoder_seq

Overview:
Parametrised successor to the single-cycle 8-to-3 encoder. Captures a WIDTH-bit request vector and emits the index of every set bit, one per beat, in priority order (LSB-first or MSB-first), over a valid/ready stream. It also reports the vector's population count and flags the all-zero case explicitly. It sits between request-vector producers (interrupt/flag registers) and serial index consumers.

Parameters:
WIDTH, 8, request vector width; must be >= 2.
IDX_W, $clog2(WIDTH), index width; derived, do not override.
MSB_FIRST, 0, 0 = lowest set bit first; 1 = highest set bit first.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous reset, active-low.
en  input  1  block enable; 0 pauses acceptance and emission.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a vector.
in_data  input  WIDTH  request vector.
out_valid  output  1  out_idx/out_last/out_none/out_cnt are valid.
out_ready  input  1  consumer accepts the current beat.
out_idx  output  IDX_W  index of the current set bit.
out_last  output  1  current beat is the final beat for this vector.
out_none  output  1  the captured vector was all zeros.
out_cnt  output  IDX_W+1  popcount of the captured vector; held for all beats.
busy  output  1  a vector is held (state != IDLE).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pending=0, out_cnt=0, zero flag=0. While rst_n is low, all outputs are 0, including in_ready.
- States: IDLE, SCAN, ZERO.
- in_ready = en & (state==IDLE). Handshake: in_valid & in_ready at a rising edge.
- In IDLE, on handshake:
  - pending <= in_data; out_cnt <= popcount(in_data).
  - Next state is ZERO if in_data==0, otherwise SCAN.
- Latency: the first out_valid occurs in the cycle after capture. in_valid while busy is ignored; the producer must hold it.
- SCAN:
  - out_valid = en.
  - out_idx = index of the lowest set bit of pending (highest if MSB_FIRST=1).
  - out_last = 1 when exactly one bit of pending is set.
  - out_none = 0.
  - On out_valid & out_ready: clear that bit in pending. If out_last, go to IDLE and set pending=0.
- ZERO:
  - out_valid = en; out_idx=0; out_last=1; out_none=1; out_cnt=0.
  - On out_valid & out_ready: go to IDLE.
- Output stability: all out_* fields are functions of registered state only and do not change while out_valid=1 and out_ready=0.
- Throughput: one index per cycle with out_ready held high. A vector of k set bits takes k beats (an all-zero vector takes 1 beat). There is one IDLE cycle with in_ready=1 between vectors.
- en=0: in_ready=0 and out_valid=0, and state and pending hold. Emission resumes at the same index when en returns to 1. out_ready is ignored while en=0.
- out_ready low: the current beat holds indefinitely.
- Wrap/width:
  - Index WIDTH-1 is a legal output.
  - If WIDTH is not a power of two, indices >= WIDTH never appear.
  - out_cnt can reach WIDTH, hence IDX_W+1 bits.
- Reset mid-operation discards the pending vector with no further beats. After rst_n rises, in_ready follows en at once.
- Outside SCAN/ZERO, out_idx, out_last and out_none are 0.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, in_data=8'h05, out_ready=1 -> beats idx=0 (last=0), then idx=2 (last=1); out_cnt=2 on both; busy drops after the second beat; in_ready=1 the next cycle.
2. MSB_FIRST=1, in_data=8'hA0 -> idx=7 (last=0), then idx=5 (last=1); out_cnt=2.
3. in_data=8'h00 -> exactly one beat with out_none=1, idx=0, last=1, out_cnt=0; return to IDLE.
4. in_data=8'h0C, out_ready=0 for 3 cycles after the first out_valid -> idx=2 held stable for those 3 cycles; then idx=2, idx=3 (last=1) once out_ready=1. Also assert in_valid with 8'hFF during the scan -> ignored, in_ready=0.
5. in_data=8'hFF, en=0 after 3 accepted beats (idx 0,1,2) for 4 cycles -> out_valid=0, no bits cleared. With en=1, beats resume at idx=3..7, last=1 on idx=7; out_cnt=8 throughout.
6. in_data=8'hF0, rst_n pulsed low after the first beat (idx=4) -> all outputs 0 immediately. After release, no further beats, busy=0, in_ready=en. A new vector 8'h02 yields a single beat idx=1, last=1.
